// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register for a 5-stage RV32I pipeline.
// Owns PCF, keeps at most one instruction-memory request outstanding, and
// parks a response in a one-entry buffer when decode is stalled.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemReady,
    input  logic            ImemValid,
    input  logic [31:0]     ImemRData,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] req_pc;

    logic            fbuf_valid;
    logic [31:0]     fbuf_instr;
    logic [XLEN-1:0] fbuf_pc;

    logic            wait_rsp_c;
    logic            issue_c;
    logic            handshake_c;
    logic            bypass_c;

    // Request/response qualifiers; a response that must be parked blocks a new issue.
    assign wait_rsp_c  = (state == S_WAIT) && ImemValid;
    assign issue_c     = !reset && ((state == S_REQ) || wait_rsp_c) && !StallF && !PCSrcE
                         && !fbuf_valid && !(wait_rsp_c && StallD);
    assign handshake_c = issue_c && ImemReady;
    assign bypass_c    = wait_rsp_c && !StallD && !FlushD && !PCSrcE;

    assign ImemReq  = issue_c;
    assign ImemAddr = pcf;

    // Request FSM, program counter and address of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_REQ;
            pcf    <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (handshake_c) begin
                req_pc <= pcf;
            end

            if (PCSrcE) begin
                pcf <= PCTargetE;
            end else if (handshake_c) begin
                pcf <= pcf + XLEN'(4);
            end

            unique case (state)
                S_REQ: begin
                    if (handshake_c) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (PCSrcE) begin
                        state <= ImemValid ? S_REQ : S_DISCARD;
                    end else if (handshake_c) begin
                        state <= S_WAIT;
                    end else if (ImemValid) begin
                        state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (ImemValid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // One-entry fetch buffer holding a response that arrived while decode stalled.
    always_ff @(posedge clk) begin
        if (reset || PCSrcE) begin
            fbuf_valid <= 1'b0;
            fbuf_instr <= '0;
            fbuf_pc    <= '0;
        end else if (wait_rsp_c && StallD) begin
            fbuf_valid <= 1'b1;
            fbuf_instr <= ImemRData;
            fbuf_pc    <= req_pc;
        end else if (fbuf_valid && !StallD && !FlushD) begin
            fbuf_valid <= 1'b0;
        end
    end

    // IF/ID register: flush beats stall, buffered entry beats a live response.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            ValidD <= ValidD;
        end else if (fbuf_valid && !PCSrcE) begin
            InstrD   <= fbuf_instr;
            PCD      <= fbuf_pc;
            PCPlus4D <= fbuf_pc + XLEN'(4);
            ValidD   <= 1'b1;
        end else if (bypass_c) begin
            InstrD   <= ImemRData;
            PCD      <= req_pc;
            PCPlus4D <= req_pc + XLEN'(4);
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction-memory model with
// programmable response latency returns the request address as the word.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        StallF    = 1'b0;
    logic        StallD    = 1'b0;
    logic        FlushD    = 1'b0;
    logic        PCSrcE    = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        ImemReady = 1'b1;
    logic        ImemValid = 1'b0;
    logic [31:0] ImemRData = '0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int          errs   = 0;
    int          checks = 0;

    // memory model state
    int          lat   = 1;
    bit          pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] paddr = '0;
    bit          live  = 1'b0;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .ImemReq  (ImemReq),
        .ImemAddr (ImemAddr),
        .ImemReady(ImemReady),
        .ImemValid(ImemValid),
        .ImemRData(ImemRData),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Account for the cycle just ending, then drive the next cycle's inputs.
    task automatic cyc(input logic rst, input logic sf, input logic sd, input logic fd,
                       input logic pc, input logic [31:0] tgt);
        if (live) begin
            if (ImemValid) pend = 1'b0;
            if (ImemReq && ImemReady) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = ImemAddr;
            end
        end
        live = 1'b1;
        @(negedge clk);
        reset     = rst;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        PCSrcE    = pc;
        PCTargetE = tgt;
        if (pend) cnt--;
        ImemValid = pend && (cnt == 0);
        ImemRData = ImemValid ? paddr : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic go();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        pend = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk_d(input string tag, input logic v, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(ValidD), 32'(v));
        check({tag, "_instr"}, InstrD, v ? pc : NOP);
        check({tag, "_pcd"}, PCD, pc);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          ev [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
        bit          er [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        logic [31:0] ep [9] = '{32'd20, 32'd20, 32'd20, 32'd24, 32'd24, 32'd24, 32'd28, 32'd28, 32'd28};

        // reset state and zero-wait streaming
        lat = 1;
        do_reset();
        check("rst_req", 32'(ImemReq), 32'd0);
        check("rst_valid", 32'(ValidD), 32'd0);
        check("rst_instr", InstrD, NOP);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pcp4", PCPlus4D, 32'd0);
        go();
        check("z0_req", 32'(ImemReq), 32'd1);
        check("z0_addr", ImemAddr, 32'd0);
        check("z0_valid", 32'(ValidD), 32'd0);
        go();
        check("z1_addr", ImemAddr, 32'd4);
        check("z1_valid", 32'(ValidD), 32'd0);
        for (int k = 2; k <= 6; k++) begin
            go();
            chk_d("zs", 1'b1, 32'(4 * (k - 2)));
            check("zs_pcp4", PCPlus4D, 32'(4 * (k - 2) + 4));
            check("zs_addr", ImemAddr, 32'(4 * k));
        end

        // switch to 3-cycle latency; request for 24 is the first slow one
        lat = 3;
        for (int i = 0; i < 9; i++) begin
            go();
            chk_d("l3", ev[i], ep[i]);
            check("l3_req", 32'(ImemReq), 32'(er[i]));
            if (er[i]) check("l3_addr", ImemAddr, 32'(28 + 4 * ((i - 2) / 3)));
        end

        // response for 0x10 lands while decode is stalled for three cycles
        lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) go();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            check("st_req", 32'(ImemReq), 32'd0);
            chk_d("st_hold", 1'b1, 32'h0C);
        end
        go();
        check("st_rel_req", 32'(ImemReq), 32'd0);
        chk_d("st_rel", 1'b1, 32'h0C);
        go();
        chk_d("st_buf", 1'b1, 32'h10);
        check("st_buf_pcp4", PCPlus4D, 32'h14);
        check("st_next_req", 32'(ImemReq), 32'd1);
        check("st_next_addr", ImemAddr, 32'h14);
        go();
        chk_d("st_nodup", 1'b0, 32'h10);
        check("st_addr2", ImemAddr, 32'h18);
        go();
        chk_d("st_after", 1'b1, 32'h14);

        // redirect while the request for 0x20 is outstanding (latency 2)
        lat = 2;
        do_reset();
        for (int i = 0; i < 16; i++) go();
        go();
        check("rd_req20", 32'(ImemReq), 32'd1);
        check("rd_addr20", ImemAddr, 32'h20);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        chk_d("rd_pre", 1'b1, 32'h1C);
        check("rd_req_blk", 32'(ImemReq), 32'd0);
        go();
        chk_d("rd_flush", 1'b0, 32'h1C);
        check("rd_disc_req", 32'(ImemReq), 32'd0);
        go();
        check("rd_tgt_req", 32'(ImemReq), 32'd1);
        check("rd_tgt_addr", ImemAddr, 32'h100);
        chk_d("rd_b1", 1'b0, 32'h1C);
        go();
        chk_d("rd_b2", 1'b0, 32'h1C);
        go();
        chk_d("rd_b3", 1'b0, 32'h1C);
        check("rd_addr104", ImemAddr, 32'h104);
        go();
        chk_d("rd_tgt_d", 1'b1, 32'h100);

        // redirect + flush + stall coincide with a response
        lat = 1;
        do_reset();
        go();
        go();
        go();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        check("rfs_req", 32'(ImemReq), 32'd0);
        chk_d("rfs_pre", 1'b1, 32'h4);
        go();
        chk_d("rfs_bub", 1'b0, 32'h4);
        check("rfs_req2", 32'(ImemReq), 32'd1);
        check("rfs_addr", ImemAddr, 32'h200);
        go();
        chk_d("rfs_b2", 1'b0, 32'h4);
        check("rfs_addr2", ImemAddr, 32'h204);
        go();
        chk_d("rfs_tgt", 1'b1, 32'h200);
        check("rfs_pcp4", PCPlus4D, 32'h204);

        // reset mid-WAIT with the stale response arriving right after
        lat = 2;
        do_reset();
        go();
        check("mr_req0", 32'(ImemReq), 32'd1);
        check("mr_addr0", ImemAddr, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("mr_rst_req", 32'(ImemReq), 32'd0);
        go();
        chk_d("mr_rst", 1'b0, 32'd0);
        check("mr_rst_pcp4", PCPlus4D, 32'd0);
        check("mr_req", 32'(ImemReq), 32'd1);
        check("mr_addr", ImemAddr, 32'd0);
        go();
        chk_d("mr_stale", 1'b0, 32'd0);
        go();
        chk_d("mr_w", 1'b0, 32'd0);
        go();
        chk_d("mr_first", 1'b1, 32'd0);
        check("mr_first_pcp4", PCPlus4D, 32'd4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
